// File: rtl/irig_b_encoder_if.sv
// Control/load inputs and code outputs of the IRIG-B encoder.
// The master side drives enable and load requests; the slave side is the encoder.
interface irig_b_encoder_if;
  logic       enable;
  logic       load_valid;
  logic [5:0] load_sec;
  logic [5:0] load_min;
  logic [4:0] load_hour;
  logic [8:0] load_day;
  logic [6:0] load_year;
  logic       load_err;
  logic       irig_out;
  logic       frame_start;
  logic       busy;

  modport master (
    output enable, load_valid, load_sec, load_min, load_hour, load_day, load_year,
    input  load_err, irig_out, frame_start, busy
  );

  modport slave (
    input  enable, load_valid, load_sec, load_min, load_hour, load_day, load_year,
    output load_err, irig_out, frame_start, busy
  );
endinterface

// File: rtl/irig_b_encoder.sv
// IRIG-B (B00x, DC level) time-code generator: keeps a time-of-year register,
// BCD-encodes it into a 100-bit frame shadow and emits one frame per second.
module irig_b_encoder #(
  parameter int CLKS_PER_MS = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  irig_b_encoder_if.slave   bus
);

  localparam int MSW = (CLKS_PER_MS > 2) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [MSW-1:0] MS_LAST = MSW'(CLKS_PER_MS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic [6:0] year;
    logic [8:0] day;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  localparam time_t TIME_RESET = '{year: 7'd0, day: 9'd1, hour: 5'd0, min: 6'd0, sec: 6'd0};

  function automatic logic [8:0] last_day(input logic [6:0] y);
    return (y[1:0] == 2'b00) ? 9'd366 : 9'd365;
  endfunction

  function automatic time_t inc_time(input time_t t);
    time_t r;
    r = t;
    if (t.sec != 6'd59) begin
      r.sec = t.sec + 6'd1;
    end else begin
      r.sec = 6'd0;
      if (t.min != 6'd59) begin
        r.min = t.min + 6'd1;
      end else begin
        r.min = 6'd0;
        if (t.hour != 5'd23) begin
          r.hour = t.hour + 5'd1;
        end else begin
          r.hour = 5'd0;
          if (t.day != last_day(t.year)) begin
            r.day = t.day + 9'd1;
          end else begin
            r.day  = 9'd1;
            r.year = (t.year == 7'd99) ? 7'd0 : t.year + 7'd1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] units(input logic [8:0] v);
    logic [8:0] r;
    r = v % 9'd10;
    return r[3:0];
  endfunction

  function automatic logic [8:0] tens_of(input logic [8:0] v);
    return v / 9'd10;
  endfunction

  // Only data bits are stored; marker positions are applied at symbol time.
  function automatic logic [99:0] build_frame(input time_t t);
    logic [99:0] f;
    logic [8:0]  sec9, min9, hour9, day9, year9, day_t;
    logic [3:0]  st, mt, ht, yt, dt, dh;
    f     = '0;
    sec9  = {3'b0, t.sec};
    min9  = {3'b0, t.min};
    hour9 = {4'b0, t.hour};
    day9  = t.day;
    year9 = {2'b0, t.year};
    day_t = tens_of(day9);
    st = units(tens_of(sec9));
    mt = units(tens_of(min9));
    ht = units(tens_of(hour9));
    yt = units(tens_of(year9));
    dt = units(day_t);
    dh = units(tens_of(day_t));
    f[4:1]   = units(sec9);
    f[8:6]   = st[2:0];
    f[13:10] = units(min9);
    f[17:15] = mt[2:0];
    f[23:20] = units(hour9);
    f[26:25] = ht[1:0];
    f[33:30] = units(day9);
    f[38:35] = dt;
    f[41:40] = dh[1:0];
    f[53:50] = units(year9);
    f[58:55] = yt;
    return f;
  endfunction

  logic [99:0] marker_mask;
  for (genvar gi = 0; gi < 100; gi++) begin : g_marker
    assign marker_mask[gi] = (gi == 0) || ((gi % 10) == 9);
  end

  state_t         state_q, state_d;
  logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
  logic [3:0]     ms_in_bit_q, ms_in_bit_d;
  logic [6:0]     bit_idx_q, bit_idx_d;
  time_t          time_q, time_d;
  time_t          pend_q, pend_d;
  logic           pend_valid_q, pend_valid_d;
  logic [99:0]    shadow_q, shadow_d;
  logic           irig_out_q, irig_out_d;
  logic           frame_start_q, frame_start_d;
  logic           busy_q, busy_d;
  logic           load_err_q, load_err_d;

  time_t      load_time;
  logic       load_ok;
  logic       ms_last, bit_last, frame_last;
  logic       run_d;
  logic [3:0] n_ms;

  assign load_time = '{year: bus.load_year, day: bus.load_day, hour: bus.load_hour,
                       min: bus.load_min, sec: bus.load_sec};

  assign load_ok = bus.load_valid
                && (bus.load_sec  <= 6'd59)
                && (bus.load_min  <= 6'd59)
                && (bus.load_hour <= 5'd23)
                && (bus.load_day  >= 9'd1)
                && (bus.load_day  <= last_day(bus.load_year))
                && (bus.load_year <= 7'd99);

  assign ms_last    = (ms_cnt_q == MS_LAST);
  assign bit_last   = ms_last && (ms_in_bit_q == 4'd9);
  assign frame_last = bit_last && (bit_idx_q == 7'd99);

  always_comb begin
    state_d      = state_q;
    ms_cnt_d     = ms_cnt_q;
    ms_in_bit_d  = ms_in_bit_q;
    bit_idx_d    = bit_idx_q;
    time_d       = time_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    load_err_d   = bus.load_valid && !load_ok;

    case (state_q)
      ST_IDLE: begin
        ms_cnt_d    = '0;
        ms_in_bit_d = '0;
        bit_idx_d   = '0;
        if (pend_valid_q) begin
          time_d       = pend_q;
          pend_valid_d = 1'b0;
        end
        if (load_ok) begin
          time_d       = load_time;
          pend_valid_d = 1'b0;
        end
        if (bus.enable) begin
          state_d  = ST_RUN;
          shadow_d = build_frame(time_d);
        end
      end
      ST_RUN: begin
        if (load_ok) begin
          pend_d       = load_time;
          pend_valid_d = 1'b1;
        end
        ms_cnt_d = ms_last ? '0 : ms_cnt_q + MSW'(1);
        if (ms_last) begin
          ms_in_bit_d = bit_last ? 4'd0 : ms_in_bit_q + 4'd1;
        end
        if (bit_last) begin
          bit_idx_d = frame_last ? 7'd0 : bit_idx_q + 7'd1;
        end
        // A strobe coinciding with the frame boundary is held for the next boundary.
        if (frame_last) begin
          time_d       = pend_valid_q ? pend_q : inc_time(time_q);
          pend_valid_d = load_ok;
          if (bus.enable) begin
            shadow_d = build_frame(time_d);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so irig_out is glitch-free.
    run_d = (state_d == ST_RUN);
    if (marker_mask[bit_idx_d]) begin
      n_ms = 4'd8;
    end else if (shadow_d[bit_idx_d]) begin
      n_ms = 4'd5;
    end else begin
      n_ms = 4'd2;
    end
    irig_out_d    = run_d && (ms_in_bit_d < n_ms);
    frame_start_d = run_d && (ms_cnt_d == '0) && (ms_in_bit_d == 4'd0) && (bit_idx_d == 7'd0);
    busy_d        = run_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ms_cnt_q      <= '0;
      ms_in_bit_q   <= '0;
      bit_idx_q     <= '0;
      time_q        <= TIME_RESET;
      pend_q        <= TIME_RESET;
      pend_valid_q  <= 1'b0;
      shadow_q      <= '0;
      irig_out_q    <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ms_cnt_q      <= ms_cnt_d;
      ms_in_bit_q   <= ms_in_bit_d;
      bit_idx_q     <= bit_idx_d;
      time_q        <= time_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      shadow_q      <= shadow_d;
      irig_out_q    <= irig_out_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      load_err_q    <= load_err_d;
    end
  end

  assign bus.irig_out    = irig_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_irig_b_encoder.sv
// Directed bench for irig_b_encoder: captures whole frames from irig_out, decodes
// them by pulse width and compares against expected times queued with each stimulus.
module tb_irig_b_encoder;

  localparam int CPM     = 4;
  localparam int BIT_CYC = 10 * CPM;

  typedef struct packed {
    logic [15:0] sec;
    logic [15:0] min;
    logic [15:0] hour;
    logic [15:0] day;
    logic [15:0] year;
  } tt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  tt_t  expq[$];

  always #5 clk = ~clk;

  irig_b_encoder_if bus_if ();

  irig_b_encoder #(.CLKS_PER_MS(CPM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic tt_t mk(input int s, input int m, input int h, input int d, input int y);
    tt_t t;
    t.sec = 16'(s); t.min = 16'(m); t.hour = 16'(h); t.day = 16'(d); t.year = 16'(y);
    return t;
  endfunction

  function automatic bit is_marker(input int b);
    return (b == 0) || ((b % 10) == 9);
  endfunction

  function automatic bit is_data(input int b);
    return b inside {[1:4], [6:8], [10:13], [15:17], [20:23], 25, 26, [30:33], [35:38],
                     40, 41, [50:53], [55:58]};
  endfunction

  function automatic tt_t decode(input int w[100]);
    int v[100];
    tt_t t;
    for (int b = 0; b < 100; b++) v[b] = (w[b] == 5 * CPM) ? 1 : 0;
    t.sec  = 16'(v[1] + 2*v[2] + 4*v[3] + 8*v[4] + 10*v[6] + 20*v[7] + 40*v[8]);
    t.min  = 16'(v[10] + 2*v[11] + 4*v[12] + 8*v[13] + 10*v[15] + 20*v[16] + 40*v[17]);
    t.hour = 16'(v[20] + 2*v[21] + 4*v[22] + 8*v[23] + 10*v[25] + 20*v[26]);
    t.day  = 16'(v[30] + 2*v[31] + 4*v[32] + 8*v[33] + 10*v[35] + 20*v[36] + 40*v[37]
                 + 80*v[38] + 100*v[40] + 200*v[41]);
    t.year = 16'(v[50] + 2*v[51] + 4*v[52] + 8*v[53] + 10*v[55] + 20*v[56] + 40*v[57]
                 + 80*v[58]);
    return t;
  endfunction

  task automatic do_load(input int s, input int m, input int h, input int d, input int y);
    bus_if.load_sec   = 6'(s);
    bus_if.load_min   = 6'(m);
    bus_if.load_hour  = 5'(h);
    bus_if.load_day   = 9'(d);
    bus_if.load_year  = 7'(y);
    bus_if.load_valid = 1'b1;
    @(negedge clk);
    bus_if.load_valid = 1'b0;
  endtask

  // Waits for frame_start, samples one frame and checks it against the queue head.
  task automatic capture(input string tag);
    int  w[100];
    int  n, busy_low, fs_cnt, bad;
    tt_t got, exp;
    n = 0;
    while (bus_if.frame_start !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " frame_start_seen"}, 80'(bus_if.frame_start), 80'(1));
    busy_low = 0;
    fs_cnt   = 0;
    for (int b = 0; b < 100; b++) begin
      w[b] = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (bus_if.irig_out === 1'b1) w[b]++;
        if (bus_if.busy !== 1'b1) busy_low++;
        if (bus_if.frame_start === 1'b1) fs_cnt++;
        @(negedge clk);
      end
    end
    bad = 0;
    for (int b = 0; b < 100; b++) begin
      if (is_marker(b)) begin
        if (w[b] != 8 * CPM) bad++;
      end else if (is_data(b)) begin
        if (w[b] != 2 * CPM && w[b] != 5 * CPM) bad++;
      end else if (w[b] != 2 * CPM) begin
        bad++;
      end
    end
    chk({tag, " symbol_shape_errors"}, 80'(bad), 80'(0));
    chk({tag, " busy_low_cycles"}, 80'(busy_low), 80'(0));
    chk({tag, " frame_start_count"}, 80'(fs_cnt), 80'(1));
    got = decode(w);
    if (expq.size() == 0) begin
      chk({tag, " scoreboard_nonempty"}, 80'(0), 80'(1));
    end else begin
      exp = expq.pop_front();
      chk({tag, " decoded_time"}, got, exp);
    end
    $display("frame %s: %0d:%0d:%0d day %0d year %0d", tag, got.hour, got.min, got.sec,
             got.day, got.year);
  endtask

  initial begin
    int cnt, n, fs_seen;
    bus_if.enable     = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_sec   = '0;
    bus_if.load_min   = '0;
    bus_if.load_hour  = '0;
    bus_if.load_day   = '0;
    bus_if.load_year  = '0;

    repeat (3) @(negedge clk);
    chk("reset irig_out", 80'(bus_if.irig_out), 80'(0));
    chk("reset busy", 80'(bus_if.busy), 80'(0));
    chk("reset frame_start", 80'(bus_if.frame_start), 80'(0));
    chk("reset load_err", 80'(bus_if.load_err), 80'(0));

    // Release with enable high: the first frame starts on the next edge.
    rst_n = 1'b1;
    bus_if.enable = 1'b1;
    @(negedge clk);
    chk("start frame_start cycle1", 80'(bus_if.frame_start), 80'(1));
    chk("start irig_out cycle1", 80'(bus_if.irig_out), 80'(1));
    chk("start busy cycle1", 80'(bus_if.busy), 80'(1));
    expq.push_back(mk(0, 0, 0, 1, 0));
    capture("f0");
    chk("seamless next frame_start", 80'(bus_if.frame_start), 80'(1));
    expq.push_back(mk(1, 0, 0, 1, 0));
    capture("f1");

    // Rejected loads during frame 2 leave the running time untouched.
    do_load(60, 0, 0, 1, 0);
    chk("bad sec load_err pulse", 80'(bus_if.load_err), 80'(1));
    @(negedge clk);
    chk("bad sec load_err single", 80'(bus_if.load_err), 80'(0));
    do_load(0, 0, 0, 366, 23);
    chk("bad day load_err pulse", 80'(bus_if.load_err), 80'(1));
    @(negedge clk);
    chk("bad day load_err single", 80'(bus_if.load_err), 80'(0));
    expq.push_back(mk(3, 0, 0, 1, 0));
    capture("f3");

    // Two valid loads in frame 4: the second overwrites the first, applied at frame 5.
    do_load(3, 2, 1, 10, 5);
    chk("good load no err", 80'(bus_if.load_err), 80'(0));
    do_load(59, 59, 23, 366, 24);
    expq.push_back(mk(59, 59, 23, 366, 24));
    capture("f5");
    expq.push_back(mk(0, 0, 0, 1, 25));
    capture("f6");

    do_load(59, 59, 23, 365, 23);
    expq.push_back(mk(59, 59, 23, 365, 23));
    capture("f8");
    expq.push_back(mk(0, 0, 0, 1, 24));
    capture("f9");

    // Drop enable at bit 40 of frame 10; the frame still runs its full length.
    cnt = 0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 5000) begin
      if (n == 40 * BIT_CYC) bus_if.enable = 1'b0;
      cnt++;
      @(negedge clk);
      n++;
    end
    chk("stop busy length", 80'(cnt), 80'(100 * BIT_CYC));
    chk("stop irig_out low", 80'(bus_if.irig_out), 80'(0));
    fs_seen = 0;
    repeat (200) begin
      if (bus_if.frame_start === 1'b1 || bus_if.busy === 1'b1) fs_seen++;
      @(negedge clk);
    end
    chk("stop no further frame", 80'(fs_seen), 80'(0));

    // Load while idle applies immediately.
    do_load(56, 34, 12, 123, 24);
    chk("idle load no err", 80'(bus_if.load_err), 80'(0));
    bus_if.enable = 1'b1;
    expq.push_back(mk(56, 34, 12, 123, 24));
    capture("f_load");

    // Reset two cycles into bit 57 of the following frame.
    repeat (57 * BIT_CYC + 2) @(negedge clk);
    chk("pre-reset busy", 80'(bus_if.busy), 80'(1));
    chk("pre-reset irig_out", 80'(bus_if.irig_out), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("async reset irig_out", 80'(bus_if.irig_out), 80'(0));
    chk("async reset busy", 80'(bus_if.busy), 80'(0));
    chk("async reset frame_start", 80'(bus_if.frame_start), 80'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expq.push_back(mk(0, 0, 0, 1, 0));
    capture("f_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
